// File: rtl/script_wait_pkg.sv
// Shared encodings for the script wait/waituntil executor.
package script_wait_pkg;

   typedef enum logic [1:0] {
      FUNC_WAIT     = 2'b00,
      FUNC_UNTIL_HI = 2'b01,
      FUNC_UNTIL_LO = 2'b10,
      FUNC_RSVD     = 2'b11
   } func_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_T = 2'd1,
      WAIT_S = 2'd2,
      DONE   = 2'd3
   } state_e;

   // Bits needed to hold 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/script_wait_if.sv
// Decoder-side request/completion bundle of the script wait unit.
interface script_wait_if #(
   parameter int NUM_W = 8,
   parameter int SEL_W = 3
);
   logic             start;
   logic             cancel;
   logic [1:0]       func;
   logic [NUM_W-1:0] i_num;
   logic [SEL_W-1:0] i_sign;
   logic             busy;
   logic             is_ready;
   logic             timed_out;

   modport master (
      output start, cancel, func, i_num, i_sign,
      input  busy, is_ready, timed_out
   );

   modport slave (
      input  start, cancel, func, i_num, i_sign,
      output busy, is_ready, timed_out
   );
endinterface

// File: rtl/script_tick_prescaler.sv
// Divides clk down to a 1-cycle tick every TICK_DIV cycles; clr restarts the period.
module script_tick_prescaler #(
   parameter int TICK_DIV = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] cnt;

   // Down-counter: terminal count 0 marks the last cycle of each period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || cnt == '0) begin
         cnt <= LAST;
      end else begin
         cnt <= cnt - PW'(1);
      end
   end

   assign tick = (cnt == '0) && !clr;

endmodule

// File: rtl/script_wait_unit.sv
// Wait / waituntil executor for the kitchen script engine.
// Optional waituntil timeout is built when SCRIPT_WAIT_TIMEOUT_EN is defined.
//
//  state  | meaning
//  IDLE   | waiting for start
//  WAIT_T | counting N*UNIT_TICKS ms ticks
//  WAIT_S | waiting for selected feedback bit to reach polarity
//  DONE   | one-cycle is_ready pulse
module script_wait_unit
   import script_wait_pkg::*;
#(
   parameter int NUM_W         = 8,
   parameter int SIG_N         = 8,
   parameter int SEL_W         = 3,
   parameter int TICK_DIV      = 100000,
   parameter int UNIT_TICKS    = 100,
   parameter int TIMEOUT_UNITS = 50
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SIG_N-1:0] feedback_sig,
   script_wait_if.slave     bus
);
   localparam int MAX_T = (2**NUM_W - 1) * UNIT_TICKS;
   localparam int TO_T  = TIMEOUT_UNITS * UNIT_TICKS;
   localparam int CNT_W = cnt_width((MAX_T > TO_T) ? MAX_T : TO_T);
   localparam int EXT_N = 2**SEL_W;

   state_e           state_q, state_d;
   func_e            func_in;
   logic             start_ok;
   logic             tick;
   logic [SIG_N-1:0] sync1, sync2;
   logic [SEL_W-1:0] sel_q;
   logic             pol_q;
   logic [CNT_W-1:0] rem_q, rem_dec, load_val;
   logic [EXT_N+SIG_N-1:0] fb_pad;
   logic [EXT_N-1:0] fb_ext;
   logic             match;

   assign func_in  = func_e'(bus.func);
   assign start_ok = (state_q == IDLE) && bus.start && !bus.cancel;

   script_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_ok),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= feedback_sig;
         sync2 <= sync1;
      end
   end

   // Zero padding makes out-of-range selects read 0.
   assign fb_pad = {{EXT_N{1'b0}}, sync2};
   assign fb_ext = fb_pad[EXT_N-1:0];
   assign match  = (fb_ext[sel_q] == pol_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q <= '0;
         pol_q <= 1'b0;
      end else if (start_ok) begin
         sel_q <= bus.i_sign;
         pol_q <= (func_in == FUNC_UNTIL_HI);
      end
   end

   always_comb begin
      load_val = '0;
      if (func_in == FUNC_WAIT) begin
         load_val = CNT_W'(bus.i_num) * CNT_W'(UNIT_TICKS);
      end
`ifdef SCRIPT_WAIT_TIMEOUT_EN
      else if (func_in == FUNC_UNTIL_HI || func_in == FUNC_UNTIL_LO) begin
         load_val = CNT_W'(TO_T);
      end
`endif
   end

   // Remaining ticks; stops at zero so it can never pass the target.
   assign rem_dec = (tick && rem_q != '0) ? rem_q - CNT_W'(1) : rem_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
      end else if (start_ok) begin
         rem_q <= load_val;
      end else if (state_q == WAIT_T || state_q == WAIT_S) begin
         rem_q <= rem_dec;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef SCRIPT_WAIT_TIMEOUT_EN
   logic to_set, to_q;
`endif

   always_comb begin
      state_d = state_q;
`ifdef SCRIPT_WAIT_TIMEOUT_EN
      to_set  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (start_ok) begin
               case (func_in)
                  FUNC_WAIT:     state_d = (bus.i_num == '0) ? DONE : WAIT_T;
                  FUNC_UNTIL_HI,
                  FUNC_UNTIL_LO: state_d = WAIT_S;
                  default:       state_d = DONE;
               endcase
            end
         end
         WAIT_T: begin
            if (bus.cancel)          state_d = IDLE;
            else if (rem_dec == '0)  state_d = DONE;
         end
         WAIT_S: begin
            if (bus.cancel)          state_d = IDLE;
            else if (match)          state_d = DONE;
`ifdef SCRIPT_WAIT_TIMEOUT_EN
            else if (rem_dec == '0) begin
               state_d = DONE;
               to_set  = 1'b1;
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef SCRIPT_WAIT_TIMEOUT_EN
   // Set on the edge entering DONE, so it is high exactly in the is_ready cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_q <= 1'b0;
      end else begin
         to_q <= to_set;
      end
   end
   assign bus.timed_out = to_q;
`else
   assign bus.timed_out = 1'b0;
`endif

   assign bus.busy     = (state_q != IDLE);
   assign bus.is_ready = (state_q == DONE);

endmodule

// File: tb/tb_script_wait_unit.sv
// Scoreboard bench for script_wait_unit (TICK_DIV=4, UNIT_TICKS=3, TIMEOUT_UNITS=2, SIG_N=4).
module tb_script_wait_unit;

   typedef struct {
      int cyc;
      bit to;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] fb;
   int         pc = 0;
   int         e0 = 0;
   int         n_chk = 0;
   int         n_fail = 0;
   exp_t       sb[$];

   script_wait_if #(.NUM_W(8), .SEL_W(3)) bus ();

   script_wait_unit #(
      .NUM_W(8), .SIG_N(4), .SEL_W(3),
      .TICK_DIV(4), .UNIT_TICKS(3), .TIMEOUT_UNITS(2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .feedback_sig (fb),
      .bus          (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) pc++;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Completion monitor: every is_ready pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (bus.is_ready) begin
         if (sb.size() == 0) begin
            check_val("ready_unexpected", bus.is_ready, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_val("ready_cycle", pc - e0 + 1, e.cyc);
            check_val("timed_out", bus.timed_out, e.to);
         end
      end else if (bus.timed_out) begin
         check_val("timed_out_unqualified", bus.timed_out, 0);
      end
   end

   // Called at a negedge; returns at the negedge of cycle 1. exp_cyc<=0 means no pulse expected.
   task automatic issue(input logic [1:0] f, input int num, input int sgn, input int exp_cyc, input bit exp_to);
      bus.func   = f;
      bus.i_num  = 8'(num);
      bus.i_sign = 3'(sgn);
      bus.start  = 1'b1;
      e0 = pc + 1;
      if (exp_cyc > 0) sb.push_back('{exp_cyc, exp_to});
      @(negedge clk);
      bus.start  = 1'b0;
      bus.func   = 2'($urandom);
      bus.i_num  = 8'($urandom);
      bus.i_sign = 3'($urandom);
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (bus.busy && n < limit) begin
         @(negedge clk);
         n++;
      end
      check_val("idle_bound", bus.busy, 0);
      @(negedge clk);
   endtask

   task automatic pulse_cancel();
      bus.cancel = 1'b1;
      @(negedge clk);
      bus.cancel = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      fb = '0;
      bus.start = 1'b0;
      bus.cancel = 1'b0;
      bus.func = '0;
      bus.i_num = '0;
      bus.i_sign = '0;
      repeat (3) @(negedge clk);
      check_val("rst_busy", bus.busy, 0);
      check_val("rst_ready", bus.is_ready, 0);
      check_val("rst_to", bus.timed_out, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset in the middle of a long timed wait.
      issue(2'b00, 5, 0, 0, 0);
      repeat (9) @(negedge clk);
      check_val("pre_rst_busy", bus.busy, 1);
      #1 rst_n = 1'b0;
      #1;
      check_val("async_rst_busy", bus.busy, 0);
      check_val("async_rst_ready", bus.is_ready, 0);
      check_val("async_rst_to", bus.timed_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (70) @(negedge clk);
      check_val("post_rst_idle", bus.busy, 0);

      // N=2: busy across cycles 1..25, pulse at 25.
      issue(2'b00, 2, 0, 25, 0);
      for (int k = 1; k <= 27; k++) begin
         check_val("busy_trace", bus.busy, (k <= 25));
         @(negedge clk);
      end

      issue(2'b00, 0, 0, 1, 0);
      wait_idle(10);
      issue(2'b11, 4, 0, 1, 0);
      wait_idle(10);
      issue(2'b00, 1, 0, 13, 0);
      wait_idle(20);
      issue(2'b00, 255, 0, 3061, 0);
      wait_idle(3100);

      // waituntil high, bit 3 raised in cycle 10.
      fb = '0;
      repeat (3) @(negedge clk);
      issue(2'b01, 0, 3, 13, 0);
      repeat (9) @(negedge clk);
      fb[3] = 1'b1;
      wait_idle(20);

      // waituntil low with condition already true.
      fb = 4'b0111;
      repeat (3) @(negedge clk);
      issue(2'b10, 0, 3, 2, 0);
      wait_idle(10);

      // Re-start while busy is dropped.
      issue(2'b00, 2, 0, 25, 0);
      repeat (4) @(negedge clk);
      bus.func = 2'b00;
      bus.i_num = 8'd0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle(40);

      // Cancel in cycle 8.
      issue(2'b00, 2, 0, 0, 0);
      repeat (7) @(negedge clk);
      pulse_cancel();
      check_val("cancel_idle", bus.busy, 0);
      repeat (30) @(negedge clk);

      // start and cancel together in IDLE.
      bus.func = 2'b00;
      bus.i_num = 8'd0;
      bus.start = 1'b1;
      bus.cancel = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.cancel = 1'b0;
      check_val("start_cancel_busy", bus.busy, 0);
      check_val("start_cancel_ready", bus.is_ready, 0);
      repeat (5) @(negedge clk);

      // Out-of-range select reads 0.
      fb = 4'b1111;
      repeat (3) @(negedge clk);
      issue(2'b10, 0, 7, 2, 0);
      wait_idle(10);

`ifdef SCRIPT_WAIT_TIMEOUT_EN
      issue(2'b01, 0, 7, 25, 1);
      wait_idle(40);
      fb = '0;
      repeat (3) @(negedge clk);
      issue(2'b01, 0, 3, 25, 1);
      wait_idle(40);
      // Match arrives in the same cycle as the timeout.
      issue(2'b01, 0, 3, 25, 0);
      repeat (21) @(negedge clk);
      fb[3] = 1'b1;
      wait_idle(40);
`else
      issue(2'b01, 0, 7, 0, 0);
      repeat (39) @(negedge clk);
      check_val("oor_hi_pending", bus.busy, 1);
      check_val("oor_hi_to", bus.timed_out, 0);
      pulse_cancel();
      check_val("oor_hi_cancel", bus.busy, 0);
      fb = '0;
      repeat (3) @(negedge clk);
      issue(2'b01, 0, 3, 0, 0);
      repeat (39) @(negedge clk);
      check_val("until_hi_pending", bus.busy, 1);
      pulse_cancel();
      check_val("until_hi_cancel", bus.busy, 0);
      repeat (5) @(negedge clk);
`endif

      check_val("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
